// File: rtl/piezo_tone_gen.sv
// Note-driven square-wave generator for the board piezo: plays one 4-bit note code per handshake for NOTE_TICKS cycles.
// Optional build macro NOTE_GAP_EN inserts a GAP_TICKS silent gap after every note.
module piezo_tone_gen #(
  parameter int NOTE_TICKS = 5_000_000,
  parameter int GAP_TICKS  = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       note_valid,
  input  logic [3:0] note_code,
  output logic       note_ready,
  output logic       piezo,
  output logic       busy,
  output logic [3:0] cur_note,
  output logic       note_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [22:0] NOTE_LAST = 23'(NOTE_TICKS - 1);
  localparam logic [22:0] NOTE_PRE  = 23'(NOTE_TICKS - 2);
`ifdef NOTE_GAP_EN
  localparam logic [22:0] GAP_LAST  = 23'(GAP_TICKS - 1);
`endif

  state_t      state;
  logic [16:0] hp_cnt;
  logic [22:0] dur_cnt;
  logic [16:0] hp_last;

  // Half periods in clk cycles at 50 MHz; code 0 (rest) never toggles, so its entry is unused.
  function automatic logic [16:0] half_period(input logic [3:0] code);
    case (code)
      4'd1:    return 17'd95556;
      4'd2:    return 17'd90194;
      4'd3:    return 17'd85133;
      4'd4:    return 17'd80353;
      4'd5:    return 17'd75843;
      4'd6:    return 17'd71586;
      4'd7:    return 17'd67569;
      4'd8:    return 17'd63776;
      4'd9:    return 17'd60197;
      4'd10:   return 17'd56818;
      4'd11:   return 17'd53630;
      4'd12:   return 17'd50620;
      4'd13:   return 17'd47778;
      4'd14:   return 17'd42566;
      4'd15:   return 17'd37921;
      default: return 17'd0;
    endcase
  endfunction

  assign hp_last    = half_period(cur_note) - 17'd1;
  assign note_ready = (state == IDLE) && enable;
  assign busy       = (state != IDLE);

  // NOTE: every register here is small control state, so all of it takes the async reset;
  // non-blocking assignments keep the next-state reads race-free within the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hp_cnt    <= '0;
      dur_cnt   <= '0;
      piezo     <= 1'b0;
      cur_note  <= '0;
      note_done <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      hp_cnt    <= '0;
      dur_cnt   <= '0;
      piezo     <= 1'b0;
      cur_note  <= '0;
      note_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          note_done <= 1'b0;
          if (note_valid) begin
            cur_note <= note_code;
            hp_cnt   <= '0;
            dur_cnt  <= '0;
            piezo    <= 1'b0;
            state    <= TONE;
          end
        end

        TONE: begin
          if (dur_cnt == NOTE_LAST) begin
            note_done <= 1'b0;
            piezo     <= 1'b0;
            cur_note  <= '0;
            hp_cnt    <= '0;
            dur_cnt   <= '0;
`ifdef NOTE_GAP_EN
            state     <= GAP;
`else
            state     <= IDLE;
`endif
          end else begin
            dur_cnt   <= dur_cnt + 23'd1;
            // Registered so the pulse lines up with the final TONE cycle.
            note_done <= (dur_cnt == NOTE_PRE);
            if (cur_note != 4'd0) begin
              if (hp_cnt == hp_last) begin
                hp_cnt <= '0;
                piezo  <= ~piezo;
              end else begin
                hp_cnt <= hp_cnt + 17'd1;
              end
            end
          end
        end

`ifdef NOTE_GAP_EN
        GAP: begin
          if (dur_cnt == GAP_LAST) begin
            dur_cnt <= '0;
            state   <= IDLE;
          end else begin
            dur_cnt <= dur_cnt + 23'd1;
          end
        end
`endif

        default: begin
          state     <= IDLE;
          hp_cnt    <= '0;
          dur_cnt   <= '0;
          piezo     <= 1'b0;
          cur_note  <= '0;
          note_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Directed bench for piezo_tone_gen: a short-note instance for timing/control and a longer one for pitch.
module tb_piezo_tone_gen;

  localparam int SN = 100;
  localparam int SG = 10;
  localparam int LN = 40000;
  localparam int LG = 5;
`ifdef NOTE_GAP_EN
  localparam int S_SPACE = SN + SG + 1;
  localparam int S_BUSY  = SN + SG;
`else
  localparam int S_SPACE = SN + 1;
  localparam int S_BUSY  = SN;
`endif

  logic clk, reset;
  logic s_enable, s_valid, s_ready, s_piezo, s_busy, s_done;
  logic [3:0] s_code, s_cur;
  logic l_enable, l_valid, l_ready, l_piezo, l_busy, l_done;
  logic [3:0] l_code, l_cur;

  int passed = 0;
  int total  = 0;

  piezo_tone_gen #(.NOTE_TICKS(SN), .GAP_TICKS(SG)) dut_short (
    .clk(clk), .reset(reset), .enable(s_enable), .note_valid(s_valid), .note_code(s_code),
    .note_ready(s_ready), .piezo(s_piezo), .busy(s_busy), .cur_note(s_cur), .note_done(s_done)
  );

  piezo_tone_gen #(.NOTE_TICKS(LN), .GAP_TICKS(LG)) dut_long (
    .clk(clk), .reset(reset), .enable(l_enable), .note_valid(l_valid), .note_code(l_code),
    .note_ready(l_ready), .piezo(l_piezo), .busy(l_busy), .cur_note(l_cur), .note_done(l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_enable = 1'b1; l_enable = 1'b1;
    s_valid = 1'b0; l_valid = 1'b0; s_code = '0; l_code = '0;
    tick(); tick();
    total++; if (s_piezo !== 1'b0) $display("FAIL reset_piezo: got %b want 0", s_piezo); else passed++;
    total++; if (s_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", s_busy); else passed++;
    total++; if (s_cur !== 4'd0) $display("FAIL reset_cur_note: got %0d want 0", s_cur); else passed++;
    total++; if (s_done !== 1'b0) $display("FAIL reset_note_done: got %b want 0", s_done); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", s_ready); else passed++;
    reset = 1'b0;
    tick();
    total++; if (s_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", s_ready); else passed++;
    total++; if (l_ready !== 1'b1) $display("FAIL post_reset_long_ready: got %b want 1", l_ready); else passed++;
    s_enable = 1'b0;
    #1;
    total++; if (s_ready !== 1'b0) $display("FAIL ready_follows_enable: got %b want 0", s_ready); else passed++;
    s_enable = 1'b1;
    #1;
  endtask

  task automatic test_pitch();
    int first_rise, rises, falls, dones, done_at, end_at;
    logic prev;
    first_rise = -1; rises = 0; falls = 0; dones = 0; done_at = -1; end_at = -1; prev = 1'b0;
    l_code = 4'd15; l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    total++; if (l_busy !== 1'b1 || l_cur !== 4'd15) $display("FAIL pitch_accept: busy=%b cur=%0d want 1/15", l_busy, l_cur); else passed++;
    for (int k = 1; k <= LN + LG + 10; k++) begin
      tick();
      if (l_piezo && !prev) begin rises++; if (first_rise < 0) first_rise = k; end
      if (!l_piezo && prev) falls++;
      prev = l_piezo;
      if (l_done) begin dones++; done_at = k; end
      if (l_cur == 4'd0 && end_at < 0) end_at = k;
    end
    total++; if (first_rise !== 37921) $display("FAIL pitch_first_rise: got %0d want 37921", first_rise); else passed++;
    total++; if (rises !== 1 || falls !== 1) $display("FAIL pitch_edges: rises=%0d falls=%0d want 1/1", rises, falls); else passed++;
    total++; if (dones !== 1 || done_at !== LN - 1) $display("FAIL pitch_done: count=%0d at=%0d want 1 at %0d", dones, done_at, LN - 1); else passed++;
    total++; if (end_at !== LN) $display("FAIL pitch_end: got %0d want %0d", end_at, LN); else passed++;
    total++; if (l_busy !== 1'b0 || l_ready !== 1'b1) $display("FAIL pitch_idle: busy=%b ready=%b want 0/1", l_busy, l_ready); else passed++;
  endtask

  task automatic test_rest();
    int highs, dones, done_at, busy_end;
    highs = 0; dones = 0; done_at = -1; busy_end = -1;
    s_code = 4'd0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    total++; if (s_busy !== 1'b1) $display("FAIL rest_busy: got %b want 1", s_busy); else passed++;
    for (int k = 1; k <= SN + SG + 5; k++) begin
      tick();
      if (s_piezo) highs++;
      if (s_done) begin dones++; done_at = k; end
      if (!s_busy && busy_end < 0) busy_end = k;
    end
    total++; if (highs !== 0) $display("FAIL rest_silent: got %0d high cycles want 0", highs); else passed++;
    total++; if (dones !== 1 || done_at !== SN - 1) $display("FAIL rest_done: count=%0d at=%0d want 1 at %0d", dones, done_at, SN - 1); else passed++;
    total++; if (busy_end !== S_BUSY) $display("FAIL rest_busy_end: got %0d want %0d", busy_end, S_BUSY); else passed++;
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int accepts, dones;
    accepts = 0; dones = 0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    s_code = 4'd15; s_valid = 1'b1;
    for (int j = 0; j < 3 * S_SPACE; j++) begin
      if (s_valid && s_ready) begin
        if (accepts < 3) acc[accepts] = j;
        accepts++;
      end
      tick();
      if (s_done) dones++;
    end
    s_valid = 1'b0;
    total++; if (accepts !== 3) $display("FAIL b2b_accepts: got %0d want 3", accepts); else passed++;
    total++; if (acc[1] - acc[0] !== S_SPACE) $display("FAIL b2b_space1: got %0d want %0d", acc[1] - acc[0], S_SPACE); else passed++;
    total++; if (acc[2] - acc[1] !== S_SPACE) $display("FAIL b2b_space2: got %0d want %0d", acc[2] - acc[1], S_SPACE); else passed++;
    total++; if (dones !== 3) $display("FAIL b2b_dones: got %0d want 3", dones); else passed++;
    for (int k = 0; k < SN + SG + 5 && s_busy; k++) tick();
    total++; if (s_busy !== 1'b0) $display("FAIL b2b_drain: busy=%b want 0", s_busy); else passed++;
  endtask

  task automatic test_enable_drop();
    int dones;
    dones = 0;
    s_code = 4'd1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int k = 1; k < 50; k++) tick();
    total++; if (s_busy !== 1'b1 || s_cur !== 4'd1) $display("FAIL en_mid_note: busy=%b cur=%0d want 1/1", s_busy, s_cur); else passed++;
    s_enable = 1'b0;
    tick();
    total++; if (s_busy !== 1'b0 || s_piezo !== 1'b0 || s_cur !== 4'd0 || s_done !== 1'b0)
      $display("FAIL en_abort: busy=%b piezo=%b cur=%0d done=%b want 0/0/0/0", s_busy, s_piezo, s_cur, s_done);
    else passed++;
    s_enable = 1'b1;
    for (int k = 0; k < SN + 5; k++) begin
      tick();
      if (s_done || s_busy) dones++;
    end
    total++; if (dones !== 0) $display("FAIL en_no_done: got %0d active cycles want 0", dones); else passed++;
    s_enable = 1'b0; s_valid = 1'b1; s_code = 4'd5;
    tick();
    s_valid = 1'b0; s_enable = 1'b1;
    total++; if (s_busy !== 1'b0) $display("FAIL en_valid_blocked: busy=%b want 0", s_busy); else passed++;
  endtask

  task automatic test_reset_mid_note();
    int done_at, busy_end;
    logic [3:0] cur_last;
    done_at = -1; busy_end = -1; cur_last = '0;
    s_code = 4'd13; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int k = 1; k < 40; k++) tick();
    reset = 1'b1;
    #1;
    total++; if (s_busy !== 1'b0 || s_cur !== 4'd0 || s_piezo !== 1'b0 || s_done !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL rst_mid: busy=%b cur=%0d piezo=%b done=%b ready=%b want 0/0/0/0/1", s_busy, s_cur, s_piezo, s_done, s_ready);
    else passed++;
    tick();
    reset = 1'b0;
    tick();
    s_code = 4'd2; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int k = 1; k <= SN + SG + 5; k++) begin
      tick();
      if (s_done && done_at < 0) begin done_at = k; cur_last = s_cur; end
      if (!s_busy && busy_end < 0) busy_end = k;
    end
    total++; if (done_at !== SN - 1 || cur_last !== 4'd2) $display("FAIL rst_restart_done: at=%0d cur=%0d want %0d/2", done_at, cur_last, SN - 1); else passed++;
    total++; if (busy_end !== S_BUSY) $display("FAIL rst_restart_len: got %0d want %0d", busy_end, S_BUSY); else passed++;
  endtask

  initial begin
    test_reset();
    test_pitch();
    test_rest();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_note();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
